ps2_key_receiver: RTL and testbench

//  PS/2 keyboard receive front end. Produces the last_key_received byte that the game-state FSM consumes
//  (e.g. 8'h29 = SPACE starts a game). Samples the keyboard's PS2_CLK/PS2_DAT lines and deframes
//  11-bit frames. Decodes scan-code set 2 make/break/extended sequences and holds the currently pressed key.

---
 rtl/ps2_key_receiver_pkg.sv | 24 ++
 rtl/ps2_key_receiver_input_filter.sv | 67 ++++++
 rtl/ps2_key_receiver.sv | 157 +++++++++++++++
 tb/tb_ps2_key_receiver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_receiver_pkg.sv
// ============================================================================
//  Module      : ps2_key_receiver_pkg
//  Description : Shared scan-code constants and frame FSM encoding for the
//                PS/2 keyboard receive front end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_key_receiver_pkg;

    localparam logic [7:0] SC_EXTENDED = 8'hE0;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_SPACE    = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

endpackage

`default_nettype wire

// File: rtl/ps2_key_receiver_input_filter.sv
// ============================================================================
//  Module      : ps2_key_receiver_input_filter
//  Description : Synchronizes PS2_CLK/PS2_DAT, deglitches the clock line and
//                emits a one-cycle pulse on each filtered falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_receiver_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk_raw,
    input  logic ps2_dat_raw,
    output logic clk_fall,
    output logic dat_sync
);

    logic       clk_meta_q, clk_sync_q;
    logic       dat_meta_q, dat_sync_q;
    logic       filt_q, filt_d;
    logic [3:0] cnt_q, cnt_d;
    logic       fall_q, fall_d;

    // The filtered level only follows the synced line after FILTER_LEN
    // consecutive disagreeing samples; any agreement restarts the count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = 4'd0;
        fall_d = 1'b0;
        if (clk_sync_q != filt_q) begin
            if (cnt_q == 4'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
                fall_d = filt_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            filt_q     <= 1'b1;
            cnt_q      <= 4'd0;
            fall_q     <= 1'b0;
        end else begin
            clk_meta_q <= ps2_clk_raw;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_dat_raw;
            dat_sync_q <= dat_meta_q;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            fall_q     <= fall_d;
        end
    end

    assign clk_fall = fall_q;
    assign dat_sync = dat_sync_q;

endmodule

`default_nettype wire

// File: rtl/ps2_key_receiver.sv
// ============================================================================
//  Module      : ps2_key_receiver
//  Description : PS/2 frame deframer plus scan-code set 2 make/break/extended
//                decoder holding the currently pressed key.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_receiver
    import ps2_key_receiver_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] last_key_received,
    output logic       key_valid,
    output logic       key_pressed,
    output logic       key_extended,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic fall, dat;

    ps2_key_receiver_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk_raw (PS2_CLK),
        .ps2_dat_raw (PS2_DAT),
        .clk_fall    (fall),
        .dat_sync    (dat)
    );

    frame_state_e  state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [7:0]    last_q, last_d;
    logic          valid_q, valid_d, pressed_q, pressed_d;
    logic          extended_q, extended_d, ferr_q, ferr_d;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tmo_d      = tmo_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        last_d     = last_q;
        valid_d    = 1'b0;
        pressed_d  = pressed_q;
        extended_d = extended_q;
        ferr_d     = 1'b0;

        if (fall) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!dat) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 4'd0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {dat, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_d = dat;
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if ((^{shift_q, parity_q}) && dat) begin
                        if (shift_q == SC_EXTENDED) begin
                            ext_d = 1'b1;
                        end else if (shift_q == SC_BREAK) begin
                            brk_d = 1'b1;
                        end else begin
                            valid_d    = 1'b1;
                            pressed_d  = !brk_q;
                            extended_d = ext_q;
                            if (!brk_q)                last_d = shift_q;
                            else if (shift_q == last_q) last_d = 8'h00;
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                    end else begin
                        // Drop any pending prefix so it cannot attach to a later byte
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end
                end
            endcase
        end else if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // Stalled mid-frame: abort the partial byte, prefixes survive
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= 4'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            last_q     <= 8'h00;
            valid_q    <= 1'b0;
            pressed_q  <= 1'b0;
            extended_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            pressed_q  <= pressed_d;
            extended_q <= extended_d;
            ferr_q     <= ferr_d;
        end
    end

    assign last_key_received = last_q;
    assign key_valid         = valid_q;
    assign key_pressed       = pressed_q;
    assign key_extended      = extended_q;
    assign frame_error       = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_receiver.sv
// ============================================================================
//  Module      : tb_ps2_key_receiver
//  Description : Self-checking bench for ps2_key_receiver with a scan-code
//                reference model and a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_receiver;
    import ps2_key_receiver_pkg::*;

    localparam int HALF = 15;
    localparam int GAP  = 60;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] last_key_received;
    logic       key_valid, key_pressed, key_extended, frame_error;

    always #10 clock = ~clock;

    ps2_key_receiver #(
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (50000)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .PS2_CLK           (ps2_clk),
        .PS2_DAT           (ps2_dat),
        .last_key_received (last_key_received),
        .key_valid         (key_valid),
        .key_pressed       (key_pressed),
        .key_extended      (key_extended),
        .frame_error       (frame_error)
    );

    typedef struct {
        bit         err;
        bit         pressed;
        bit         ext;
        logic [7:0] last;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         ev_count = 0;
    bit         m_ext = 0, m_brk = 0;
    logic [7:0] m_last = 8'h00;

    // Reference model: scan-code set 2 rules applied to whole bytes
    task automatic model_byte(input logic [7:0] b, input bit good);
        exp_t e;
        if (!good) begin
            e = '{1'b1, 1'b0, 1'b0, m_last};
            sb.push_back(e);
            m_ext = 0;
            m_brk = 0;
        end else if (b == SC_EXTENDED) begin
            m_ext = 1;
        end else if (b == SC_BREAK) begin
            m_brk = 1;
        end else begin
            if (!m_brk)          m_last = b;
            else if (b == m_last) m_last = 8'h00;
            e = '{1'b0, !m_brk, m_ext, m_last};
            sb.push_back(e);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic ps2_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit glitch);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            ps2_dat = f[i];
            if (glitch) begin
                repeat (6) @(negedge clock);
                ps2_clk = 1'b0;
                repeat (2) @(negedge clock);
                ps2_clk = 1'b1;
                repeat (HALF - 8) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                        input bit glitch = 0);
        model_byte(b, !bad_par && !bad_stop);
        ps2_bits(b, bad_par, bad_stop, 11, glitch);
        repeat (GAP) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL frame_response byte=%h: %0d expected responses still pending, required 0",
                     b, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({last_key_received, key_valid, key_pressed, key_extended, frame_error} != 12'h000) begin
            errors++;
            $display("FAIL %s: last=%h valid=%b pressed=%b ext=%b ferr=%b, required all 0",
                     name, last_key_received, key_valid, key_pressed, key_extended, frame_error);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (!reset && (key_valid || frame_error)) begin
            exp_t e;
            ev_count++;
            checks++;
            if (key_valid && frame_error) begin
                errors++;
                $display("FAIL pulse_exclusive: key_valid=1 frame_error=1, required at most one");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: valid=%b ferr=%b last=%h, required no pulse",
                         key_valid, frame_error, last_key_received);
            end else begin
                e = sb.pop_front();
                if (e.err) begin
                    if (!frame_error || last_key_received != e.last) begin
                        errors++;
                        $display("FAIL frame_error_event: ferr=%b last=%h, required ferr=1 last=%h",
                                 frame_error, last_key_received, e.last);
                    end
                end else if (!key_valid || key_pressed != e.pressed ||
                             key_extended != e.ext || last_key_received != e.last) begin
                    errors++;
                    $display("FAIL key_event: valid=%b pressed=%b ext=%b last=%h, required valid=1 pressed=%b ext=%b last=%h",
                             key_valid, key_pressed, key_extended, last_key_received,
                             e.pressed, e.ext, e.last);
                end
            end
        end
    end

    initial begin
        int         e0;
        logic [7:0] code;
        bit         r_ext, r_brk, r_bad;

        repeat (5) @(negedge clock);
        check_outputs_zero("reset_state");
        reset = 1'b0;
        repeat (20) @(negedge clock);

        // Make, typematic repeat, break, break of a non-held key
        send(SC_SPACE);
        send(SC_SPACE);
        send(SC_BREAK);
        send(SC_SPACE);
        send(SC_SPACE);
        send(SC_BREAK);
        send(8'h1C);

        // Extended make and break
        send(SC_EXTENDED);
        send(8'h75);
        send(SC_EXTENDED);
        send(SC_BREAK);
        send(8'h75);

        // Bad parity, bad stop, and a bad frame cancelling a pending break
        send(SC_SPACE, 1, 0);
        send(SC_SPACE, 0, 1);
        send(SC_BREAK);
        send(8'h44, 1, 0);
        send(SC_SPACE);

        // Stall after start + 5 data bits
        model_byte(8'h00, 0);
        ps2_bits(8'h5A, 0, 0, 6, 0);
        e0 = ev_count;
        repeat (49850) @(negedge clock);
        checks++;
        if (ev_count != e0) begin
            errors++;
            $display("FAIL timeout_early: %0d events before 50000 idle cycles, required 0", ev_count - e0);
        end
        for (int i = 0; i < 300 && ev_count == e0; i++) @(negedge clock);
        checks++;
        if (ev_count != e0 + 1) begin
            errors++;
            $display("FAIL timeout_fire: %0d events in window, required 1", ev_count - e0);
            sb.delete();
        end
        repeat (GAP) @(negedge clock);
        send(8'h1C);

        // Glitches on the clock line, then reset mid-frame
        send(8'h6B, 0, 0, 1);
        send(SC_EXTENDED, 0, 0, 1);
        ps2_bits(8'h33, 0, 0, 5, 0);
        @(negedge clock);
        reset = 1'b1;
        m_ext = 0; m_brk = 0; m_last = 8'h00;
        repeat (2) @(negedge clock);
        check_outputs_zero("mid_frame_reset");
        reset = 1'b0;
        repeat (GAP) @(negedge clock);
        check_outputs_zero("post_reset_idle");
        send(SC_BREAK);
        send(SC_SPACE);
        send(SC_SPACE);

        // Randomized keystroke sequences
        for (int n = 0; n < 20; n++) begin
            code  = 8'($urandom_range(1, 8'h83));
            r_ext = ($urandom_range(0, 3) == 0);
            r_brk = ($urandom_range(0, 2) == 0);
            r_bad = ($urandom_range(0, 7) == 0);
            if (r_brk && m_last != 8'h00 && $urandom_range(0, 1) == 1) code = m_last;
            if (r_ext) send(SC_EXTENDED);
            if (r_brk) send(SC_BREAK);
            send(code, r_bad, 0, 1'($urandom_range(0, 1)));
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
